// File: rtl/dsm_cic_decimator_if.sv
// Stream channel bundle used for both the 1-bit input and the PCM output of the decimator.
// A transfer happens on a rising edge where tvalid and tready are both high; a master holds tdata/tvalid stable until then.
interface dsm_cic_decimator_if #(
   parameter int W = 1
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dsm_cic_decimator.sv
// CIC decimator recovering signed PCM samples from a 1-bit delta-sigma stream (one instance per rail).
// Build macro DSM_CIC_ROUND_EN: round-half-up before the output shift instead of plain truncation.
module dsm_cic_decimator #(
   parameter int ORDER    = 3,
   parameter int DEC_LOG2 = 6,
   parameter int WIDTH    = 16
) (
   input  logic                aclk,
   input  logic                arst,
   dsm_cic_decimator_if.slave  s_axis_data,
   dsm_cic_decimator_if.master m_axis_data
);
   localparam int ACC_W = ORDER*DEC_LOG2 + 2;
   localparam int SHIFT = ORDER*DEC_LOG2 + 1 - WIDTH;
   localparam logic signed [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef DSM_CIC_ROUND_EN
   localparam logic signed [ACC_W-1:0] RND = ACC_W'((1 << SHIFT) >> 1);
`endif

   logic signed [ACC_W-1:0] integ    [ORDER];
   logic signed [ACC_W-1:0] dly      [ORDER];
   logic signed [ACC_W-1:0] stage_in [ORDER];
   logic signed [ACC_W-1:0] comb_in, full, acc, scaled, x;
   logic [DEC_LOG2-1:0]     cnt;
   logic [WIDTH-1:0]        out_d, sat;
   logic                    fe_pend, comb_v, out_v;
   logic                    accepted, frame_end, out_free, pending;

   // Only stall on the frame-end beat, and only if its sample would have nowhere to go.
   assign out_free  = !out_v || m_axis_data.tready;
   assign pending   = fe_pend || comb_v || (out_v && !m_axis_data.tready);
   assign s_axis_data.tready = !((cnt == '1) && pending);
   assign accepted  = s_axis_data.tvalid && s_axis_data.tready;
   assign frame_end = accepted && (cnt == '1);
   assign x         = s_axis_data.tdata[0] ? ONE : '1;

   assign m_axis_data.tdata  = out_d;
   assign m_axis_data.tvalid = out_v;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         for (int k = 0; k < ORDER; k++) integ[k] <= '0;
         cnt     <= '0;
         fe_pend <= 1'b0;
      end else begin
         fe_pend <= frame_end;
         if (accepted) begin
            cnt      <= cnt + DEC_LOG2'(1);
            integ[0] <= integ[0] + x;
            for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
         end
      end
   end

   always_comb begin
      acc = comb_in;
      for (int k = 0; k < ORDER; k++) begin
         stage_in[k] = acc;
         acc         = acc - dly[k];
      end
      full = acc;
   end

`ifdef DSM_CIC_ROUND_EN
   assign scaled = (full + RND) >>> SHIFT;
`else
   assign scaled = full >>> SHIFT;
`endif

   always_comb begin
      if (scaled > SAT_MAX)      sat = WIDTH'(SAT_MAX);
      else if (scaled < SAT_MIN) sat = WIDTH'(SAT_MIN);
      else                       sat = WIDTH'(scaled);
   end

   // Comb delays advance only when a frame result actually moves into the output register.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         comb_in <= '0;
         comb_v  <= 1'b0;
         out_v   <= 1'b0;
         out_d   <= '0;
         for (int k = 0; k < ORDER; k++) dly[k] <= '0;
      end else begin
         if (fe_pend) begin
            comb_in <= integ[ORDER-1];
            comb_v  <= 1'b1;
         end else if (comb_v && out_free) begin
            comb_v <= 1'b0;
         end
         if (comb_v && out_free) begin
            for (int k = 0; k < ORDER; k++) dly[k] <= stage_in[k];
            out_d <= sat;
            out_v <= 1'b1;
         end else if (out_v && m_axis_data.tready) begin
            out_d <= '0;
            out_v <= 1'b0;
         end
      end
   end
endmodule
